// File: rtl/seq_serializer.sv
// seq_serializer: parallel-to-serial front end; valid/ready word load, each bit held DIV cycles.
// Define SER_LSB_FIRST_EN to send load_data[0] first; default build sends MSB first.
module seq_serializer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIV   = 4
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             dout,
    output logic             bit_strobe,
    output logic             busy,
    output logic             done
);
    localparam int unsigned BW = $clog2(WIDTH);
    localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [BW-1:0] BitLast = BW'(WIDTH - 1);
    localparam logic [DW-1:0] DivLast = DW'(DIV - 1);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DW-1:0]    div_cnt_q, div_cnt_d;
    logic             dout_q, dout_d;
    logic             strobe_q, strobe_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic last_div, last_bit, word_end, accept;

    assign last_div   = (div_cnt_q == DivLast);
    assign last_bit   = (bit_cnt_q == BitLast);
    assign word_end   = (state_q == StShift) && last_div && last_bit;
    assign load_ready = (state_q == StIdle) || word_end;
    assign accept     = load_valid && load_ready;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q   <= StIdle;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            div_cnt_q <= '0;
            dout_q    <= 1'b0;
            strobe_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            div_cnt_q <= div_cnt_d;
            dout_q    <= dout_d;
            strobe_q  <= strobe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StShift;
            StShift: if (word_end && !accept) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        div_cnt_d = div_cnt_q;
        strobe_d  = 1'b0;
        done_d    = word_end;
        if (accept) begin
            // Reload also covers the back-to-back case on the last cycle of a word.
            shreg_d   = load_data;
            bit_cnt_d = '0;
            div_cnt_d = '0;
            strobe_d  = 1'b1;
        end else if (state_q == StShift) begin
            div_cnt_d = last_div ? '0 : div_cnt_q + DW'(1);
            if (last_div && last_bit) begin
                bit_cnt_d = '0;
            end else if (last_div) begin
`ifdef SER_LSB_FIRST_EN
                shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
`else
                shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
`endif
                bit_cnt_d = bit_cnt_q + BW'(1);
                strobe_d  = 1'b1;
            end
        end
        busy_d = (state_d == StShift);
`ifdef SER_LSB_FIRST_EN
        dout_d = busy_d ? shreg_d[0] : 1'b0;
`else
        dout_d = busy_d ? shreg_d[WIDTH-1] : 1'b0;
`endif
    end

    assign dout       = dout_q;
    assign bit_strobe = strobe_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_seq_serializer.sv
// Bench for seq_serializer: DIV=4 and DIV=1 instances checked cycle by cycle against a queue.
module tb_seq_serializer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       clr_n;
    logic [7:0] ld, ld1;
    logic       lv, lv1;
    logic       load_ready, dout, bit_strobe, busy, done;
    logic       ready1, dout1, strobe1, busy1, done1;

    seq_serializer #(.WIDTH(8), .DIV(4)) u_dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .load_data  (ld),
        .load_valid (lv),
        .load_ready (load_ready),
        .dout       (dout),
        .bit_strobe (bit_strobe),
        .busy       (busy),
        .done       (done)
    );

    seq_serializer #(.WIDTH(8), .DIV(1)) u_dut1 (
        .clk        (clk),
        .clr_n      (clr_n),
        .load_data  (ld1),
        .load_valid (lv1),
        .load_ready (ready1),
        .dout       (dout1),
        .bit_strobe (strobe1),
        .busy       (busy1),
        .done       (done1)
    );

    // Expected {dout, bit_strobe, busy, done, load_ready} for one cycle.
    typedef struct packed {
        logic d;
        logic s;
        logic b;
        logic dn;
        logic r;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic exp_bit(logic [7:0] data, int i);
`ifdef SER_LSB_FIRST_EN
        return data[i];
`else
        return data[7-i];
`endif
    endfunction

    function automatic void push_word(int sel, logic [7:0] data, int div, logic first_done);
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < div; k++) begin
                e.d  = exp_bit(data, i);
                e.s  = (k == 0);
                e.b  = 1'b1;
                e.dn = first_done && (i == 0) && (k == 0);
                e.r  = (i == 7) && (k == div - 1);
                if (sel == 0) q0.push_back(e);
                else q1.push_back(e);
            end
        end
    endfunction

    function automatic void push_idle(int sel, logic dn);
        exp_t e;
        e = '{d: 1'b0, s: 1'b0, b: 1'b0, dn: dn, r: 1'b1};
        if (sel == 0) q0.push_back(e);
        else q1.push_back(e);
    endfunction

    task automatic test_reset();
        exp_t e;
        clr_n = 1'b0;
        lv    = 1'b1;
        ld    = 8'hC3;
        lv1   = 1'b1;
        ld1   = 8'h3C;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({dout, bit_strobe, busy, done, load_ready} !== 5'b00001) begin
                n_bad++;
                $display("FAIL reset_hold c=%0d: got %b want 00001", c,
                         {dout, bit_strobe, busy, done, load_ready});
            end
            n_cmp++;
            if ({dout1, strobe1, busy1, done1, ready1} !== 5'b00001) begin
                n_bad++;
                $display("FAIL reset_hold_div1 c=%0d: got %b want 00001", c,
                         {dout1, strobe1, busy1, done1, ready1});
            end
        end
        lv1   = 1'b0;
        clr_n = 1'b1;
        push_word(0, 8'hC3, 4, 1'b0);
        push_idle(0, 1'b1);
        push_idle(0, 1'b0);
        for (int c = 0; c < 34; c++) begin
            @(negedge clk);
            lv = 1'b0;
            e  = q0.pop_front();
            n_cmp++;
            if ({dout, bit_strobe, busy, done, load_ready} !== e) begin
                n_bad++;
                $display("FAIL reset_release c=%0d: got %b want %b", c,
                         {dout, bit_strobe, busy, done, load_ready}, e);
            end
        end
    endtask

    task automatic test_single_word();
        exp_t e;
        @(negedge clk);
        lv = 1'b1;
        ld = 8'h88;
        push_word(0, 8'h88, 4, 1'b0);
        push_idle(0, 1'b1);
        push_idle(0, 1'b0);
        for (int c = 0; c < 34; c++) begin
            @(negedge clk);
            lv = 1'b0;
            e  = q0.pop_front();
            n_cmp++;
            if ({dout, bit_strobe, busy, done, load_ready} !== e) begin
                n_bad++;
                $display("FAIL single_word c=%0d: got %b want %b", c,
                         {dout, bit_strobe, busy, done, load_ready}, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        @(negedge clk);
        lv = 1'b1;
        ld = 8'h88;
        push_word(0, 8'h88, 4, 1'b0);
        push_word(0, 8'hF0, 4, 1'b1);
        push_idle(0, 1'b1);
        push_idle(0, 1'b0);
        for (int c = 0; c < 66; c++) begin
            @(negedge clk);
            if (c == 0) ld = 8'hF0;
            if (c == 32) lv = 1'b0;
            e = q0.pop_front();
            n_cmp++;
            if ({dout, bit_strobe, busy, done, load_ready} !== e) begin
                n_bad++;
                $display("FAIL back_to_back c=%0d: got %b want %b", c,
                         {dout, bit_strobe, busy, done, load_ready}, e);
            end
        end
    endtask

    task automatic test_reset_mid_word();
        exp_t e;
        @(negedge clk);
        lv = 1'b1;
        ld = 8'hFF;
        push_word(0, 8'hFF, 4, 1'b0);
        // Cycle 12 is the first cycle of bit 3.
        for (int c = 0; c < 13; c++) begin
            @(negedge clk);
            lv = 1'b0;
            e  = q0.pop_front();
            n_cmp++;
            if ({dout, bit_strobe, busy, done, load_ready} !== e) begin
                n_bad++;
                $display("FAIL mid_word_pre c=%0d: got %b want %b", c,
                         {dout, bit_strobe, busy, done, load_ready}, e);
            end
        end
        clr_n = 1'b0;
        #1;
        n_cmp++;
        if ({dout, bit_strobe, busy, done, load_ready} !== 5'b00001) begin
            n_bad++;
            $display("FAIL mid_word_async: got %b want 00001",
                     {dout, bit_strobe, busy, done, load_ready});
        end
        q0.delete();
        lv = 1'b1;
        ld = 8'h80;
        @(negedge clk);
        n_cmp++;
        if ({dout, bit_strobe, busy, done, load_ready} !== 5'b00001) begin
            n_bad++;
            $display("FAIL mid_word_held: got %b want 00001",
                     {dout, bit_strobe, busy, done, load_ready});
        end
        clr_n = 1'b1;
        push_word(0, 8'h80, 4, 1'b0);
        push_idle(0, 1'b1);
        push_idle(0, 1'b0);
        for (int c = 0; c < 34; c++) begin
            @(negedge clk);
            lv = 1'b0;
            e  = q0.pop_front();
            n_cmp++;
            if ({dout, bit_strobe, busy, done, load_ready} !== e) begin
                n_bad++;
                $display("FAIL mid_word_reload c=%0d: got %b want %b", c,
                         {dout, bit_strobe, busy, done, load_ready}, e);
            end
        end
    endtask

    task automatic test_div1();
        exp_t e;
        @(negedge clk);
        lv1 = 1'b1;
        ld1 = 8'hA5;
        push_word(1, 8'hA5, 1, 1'b0);
        push_idle(1, 1'b1);
        push_idle(1, 1'b0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            lv1 = 1'b0;
            e   = q1.pop_front();
            n_cmp++;
            if ({dout1, strobe1, busy1, done1, ready1} !== e) begin
                n_bad++;
                $display("FAIL div1 c=%0d: got %b want %b", c,
                         {dout1, strobe1, busy1, done1, ready1}, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_reset_mid_word();
        test_div1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
